flow_ctrl_unit: RTL and testbench

- Program-flow end of the ALU interface: consumes ALU result flags (zero/sign/carry/mode) into the status register (SR).
- Executes the program-flow class: TRAP, NOP, JMP, JZ, JS, JZS, LSR, XSR.
- Produces PC-load requests to the fetch stage and holds the core in trap mode until software acknowledges.

---
 rtl/flow_ctrl_unit_if.sv | 32 +++
 rtl/flow_ctrl_unit.sv | 107 ++++++++++
 tb/tb_flow_ctrl_unit.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/flow_ctrl_unit_if.sv
// Handshake and status bundle between the ALU/decode side and the flow control unit.
interface flow_ctrl_unit_if #(
    parameter int unsigned WIDTH = 20
);
    logic             res_valid;
    logic             res_ready;
    logic             res_zero;
    logic             res_sign;
    logic             res_carry;
    logic             res_mode;
    logic             flow_valid;
    logic             flow_ready;
    logic [2:0]       flow_op;
    logic [WIDTH-1:0] flow_operand;
    logic             trap_ack;
    logic             pc_load;
    logic [WIDTH-1:0] pc_target;
    logic [WIDTH-1:0] status;
    logic             trap;

    modport master (
        output res_valid, res_zero, res_sign, res_carry, res_mode,
        output flow_valid, flow_op, flow_operand, trap_ack,
        input  res_ready, flow_ready, pc_load, pc_target, status, trap
    );

    modport slave (
        input  res_valid, res_zero, res_sign, res_carry, res_mode,
        input  flow_valid, flow_op, flow_operand, trap_ack,
        output res_ready, flow_ready, pc_load, pc_target, status, trap
    );
endinterface

// File: rtl/flow_ctrl_unit.sv
// Program-flow unit: status register, flow-class execution and PC-load requests.
// Define FLOW_FWD_EN to forward same-cycle ALU flags into conditional jumps.
module flow_ctrl_unit #(
    parameter int unsigned      WIDTH    = 20,
    parameter logic [WIDTH-1:0] TRAP_VEC = 20'h00010
) (
    input logic             clk,
    input logic             rst_n,
    flow_ctrl_unit_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StIssue, StTrap} state_e;
    typedef enum logic [2:0] {OpTrap, OpNop, OpJmp, OpJz, OpJs, OpJzs, OpLsr, OpXsr} op_e;

    state_e           state_q, state_d;
    logic             active_q;
    logic             trap_pend_q, trap_pend_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] pc_target_q, pc_target_d;
    logic             res_hs, flow_hs, flow_rdy;
    logic             cond_z, cond_s, take;
    op_e              op;

    assign op      = op_e'(bus.flow_op);
    assign res_hs  = bus.res_valid & active_q;
    assign flow_hs = bus.flow_valid & flow_rdy;

`ifdef FLOW_FWD_EN
    assign flow_rdy = active_q & (state_q == StIdle);
    assign cond_z   = res_hs ? bus.res_zero : status_q[0];
    assign cond_s   = res_hs ? bus.res_sign : status_q[1];
`else
    // Hold off flow while flags are arriving so jumps see the committed SR.
    assign flow_rdy = active_q & (state_q == StIdle) & ~bus.res_valid;
    assign cond_z   = status_q[0];
    assign cond_s   = status_q[1];
`endif

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        pc_target_d = pc_target_q;
        trap_pend_d = trap_pend_q;
        take        = 1'b0;
        if (res_hs) begin
            status_d[3:0] = {bus.res_mode, bus.res_carry, bus.res_sign, bus.res_zero};
        end
        case (state_q)
            StIdle: begin
                if (flow_hs) begin
                    unique case (op)
                        OpTrap: begin
                            status_d[4] = 1'b1;
                            pc_target_d = TRAP_VEC;
                            trap_pend_d = 1'b1;
                            state_d     = StIssue;
                        end
                        OpNop:  take = 1'b0;
                        OpJmp:  take = 1'b1;
                        OpJz:   take = cond_z;
                        OpJs:   take = cond_s;
                        OpJzs:  take = cond_z | cond_s;
                        OpLsr:  status_d = bus.flow_operand;
                        OpXsr:  status_d = status_q ^ bus.flow_operand;
                    endcase
                    if (take) begin
                        pc_target_d = bus.flow_operand;
                        state_d     = StIssue;
                    end
                end
            end
            StIssue: begin
                state_d     = trap_pend_q ? StTrap : StIdle;
                trap_pend_d = 1'b0;
            end
            StTrap: begin
                if (bus.trap_ack) begin
                    status_d[4] = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            active_q    <= 1'b0;
            trap_pend_q <= 1'b0;
            status_q    <= '0;
            pc_target_q <= '0;
        end else begin
            state_q     <= state_d;
            active_q    <= 1'b1;
            trap_pend_q <= trap_pend_d;
            status_q    <= status_d;
            pc_target_q <= pc_target_d;
        end
    end

    assign bus.res_ready  = active_q;
    assign bus.flow_ready = flow_rdy;
    assign bus.pc_load    = (state_q == StIssue);
    assign bus.pc_target  = pc_target_q;
    assign bus.status     = status_q;
    assign bus.trap       = status_q[4];
endmodule

// File: tb/tb_flow_ctrl_unit.sv
// Scoreboard bench for flow_ctrl_unit: directed test-plan scenarios plus random traffic.
// Honours FLOW_FWD_EN the same way as the design.
module tb_flow_ctrl_unit;
    localparam logic [19:0] TV = 20'h00010;
`ifdef FLOW_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam bit [2:0] TRAP = 3'd0, NOP = 3'd1, JMP = 3'd2, JZ = 3'd3, JS = 3'd4,
                         JZS = 3'd5, LSR = 3'd6, XSR = 3'd7;

    typedef struct {
        int          due;
        logic [19:0] tgt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    // Reference model: SR contents, cycles left in a PC issue, trap occupancy.
    logic [19:0] m_sr = '0;
    int          m_issue = 0;
    bit          m_trapped = 1'b0;
    bit          m_active = 1'b0;
    bit          last_fhs = 1'b0;

    flow_ctrl_unit_if #(.WIDTH(20)) bus ();

    flow_ctrl_unit #(.WIDTH(20), .TRAP_VEC(TV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pc_load strobe must match the oldest expected issue, on time.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.pc_load) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pc_load_unexpected: got target %0h expected none", bus.pc_target);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pc_load_cycle", cyc, e.due);
                    chk("pc_target", bus.pc_target, e.tgt);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL pc_load_missing: got none expected target %0h", e.tgt);
            end
        end
    end

    task automatic drive(input bit rv, input bit [3:0] flg, input bit fv, input bit [2:0] op,
                         input bit [19:0] opd, input bit ack);
        bus.res_valid    = rv;
        bus.res_zero     = flg[0];
        bus.res_sign     = flg[1];
        bus.res_carry    = flg[2];
        bus.res_mode     = flg[3];
        bus.flow_valid   = fv;
        bus.flow_op      = op;
        bus.flow_operand = opd;
        bus.trap_ack     = ack;
    endtask

    // One clock: check registered state, drive inputs, predict the coming edge.
    task automatic step(input bit rv, input bit [3:0] flg, input bit fv, input bit [2:0] op,
                        input bit [19:0] opd, input bit ack);
        bit          exp_fr, rhs, fhs, cz, cs, take;
        logic [19:0] nsr;
        @(negedge clk);
        chk("status", bus.status, m_sr);
        chk("trap", bus.trap, m_sr[4]);
        drive(rv, flg, fv, op, opd, ack);
        #1;
        exp_fr = m_active && m_issue == 0 && !m_trapped && (FWD || !rv);
        chk("res_ready", bus.res_ready, m_active);
        chk("flow_ready", bus.flow_ready, exp_fr);
        rhs  = rv && m_active;
        fhs  = fv && exp_fr;
        cz   = (FWD && rhs) ? flg[0] : m_sr[0];
        cs   = (FWD && rhs) ? flg[1] : m_sr[1];
        take = 1'b0;
        nsr  = m_sr;
        if (rhs) nsr[3:0] = flg;
        if (m_issue > 0) m_issue--;
        else if (m_trapped && ack) begin
            m_trapped = 1'b0;
            nsr[4]    = 1'b0;
        end
        if (fhs) begin
            case (op)
                TRAP: begin
                    nsr[4]    = 1'b1;
                    m_trapped = 1'b1;
                    m_issue   = 1;
                    exp_q.push_back('{due: cyc + 1, tgt: TV});
                end
                JMP:     take = 1'b1;
                JZ:      take = cz;
                JS:      take = cs;
                JZS:     take = cz | cs;
                LSR:     nsr = opd;
                XSR:     nsr = m_sr ^ opd;
                default: take = 1'b0;
            endcase
        end
        if (take) begin
            m_issue = 1;
            exp_q.push_back('{due: cyc + 1, tgt: opd});
        end
        m_sr     = nsr;
        m_active = 1'b1;
        last_fhs = fhs;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, NOP, 20'h0, 1'b0);
    endtask

    // Hold a flow instruction valid until the model says it is accepted.
    task automatic issue(input bit [2:0] op, input bit [19:0] opd, input bit rv0,
                         input bit [3:0] flg0);
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            step(i == 0 ? rv0 : 1'b0, flg0, 1'b1, op, opd, 1'b0);
            done = last_fhs;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got no accept expected accept of op %0d", op);
        end
    endtask

    // Assert reset mid-cycle, check outputs drop without an edge, release on the next negedge.
    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        chk("rst_pc_load", bus.pc_load, 1'b0);
        chk("rst_trap", bus.trap, 1'b0);
        chk("rst_status", bus.status, 20'h0);
        chk("rst_res_ready", bus.res_ready, 1'b0);
        chk("rst_flow_ready", bus.flow_ready, 1'b0);
        m_sr      = '0;
        m_issue   = 0;
        m_trapped = 1'b0;
        exp_q.delete();
        drive(1'b0, 4'h0, 1'b0, NOP, 20'h0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk("rel_res_ready", bus.res_ready, 1'b0);
        chk("rel_flow_ready", bus.flow_ready, 1'b0);
        m_active = 1'b1;
    endtask

    initial begin
        drive(1'b0, 4'h0, 1'b0, NOP, 20'h0, 1'b0);
        #12;
        chk("init_status", bus.status, 20'h0);
        chk("init_pc_load", bus.pc_load, 1'b0);
        chk("init_pc_target", bus.pc_target, 20'h0);
        chk("init_res_ready", bus.res_ready, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk("rel_flow_ready", bus.flow_ready, 1'b0);
        m_active = 1'b1;
        idle(2);

        // Flags Z=1 S=0, then JZ taken and JS not taken.
        step(1'b1, 4'b0001, 1'b0, NOP, 20'h0, 1'b0);
        issue(JZ, 20'h00100, 1'b0, 4'h0);
        idle(2);
        issue(JS, 20'h00200, 1'b0, 4'h0);
        idle(2);

        // JZS taken on S, then not taken with both clear.
        step(1'b1, 4'b0010, 1'b0, NOP, 20'h0, 1'b0);
        issue(JZS, 20'h00300, 1'b0, 4'h0);
        idle(2);
        step(1'b1, 4'b0000, 1'b0, NOP, 20'h0, 1'b0);
        issue(JZS, 20'h00400, 1'b0, 4'h0);
        idle(2);

        // SR load/xor, then a flag update colliding with LSR.
        issue(LSR, 20'hF000F, 1'b0, 4'h0);
        issue(XSR, 20'h0000F, 1'b0, 4'h0);
        idle(1);
        chk("xsr_status", bus.status, 20'hF0000);
        issue(LSR, 20'h00005, 1'b1, 4'b1010);
        idle(1);
        chk("lsr_wins", bus.status, 20'h00005);

        // TRAP: held JMP refused until acknowledged.
        issue(TRAP, 20'h0, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b1, JMP, 20'h00600, 1'b0);
        chk("trap_held", bus.trap, 1'b1);
        step(1'b0, 4'h0, 1'b1, JMP, 20'h00600, 1'b1);
        issue(JMP, 20'h00600, 1'b0, 4'h0);
        chk("trap_cleared", bus.trap, 1'b0);
        idle(2);

        // Same-edge Z=1 and JZ with SR Z=0 beforehand.
        step(1'b1, 4'b0000, 1'b0, NOP, 20'h0, 1'b0);
        issue(JZ, 20'h00500, 1'b1, 4'b0001);
        idle(2);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 2) == 0, 4'($urandom), $urandom_range(0, 1) == 1,
                 3'($urandom), 20'($urandom), $urandom_range(0, 3) == 0);
        end

        // Drain to idle, then reset in the middle of a JMP issue.
        for (int i = 0; i < 20 && (m_issue != 0 || m_trapped); i++) begin
            step(1'b0, 4'h0, 1'b0, NOP, 20'h0, 1'b1);
        end
        issue(JMP, 20'h00ABC, 1'b0, 4'h0);
        @(negedge clk);
        #2;
        chk("pre_rst_pc_load", bus.pc_load, 1'b1);
        chk("pre_rst_pc_target", bus.pc_target, 20'h00ABC);
        reset_now();
        idle(2);

        // Reset while trapped.
        issue(TRAP, 20'h0, 1'b0, 4'h0);
        idle(2);
        @(negedge clk);
        #2;
        chk("pre_rst_trap", bus.trap, 1'b1);
        reset_now();
        idle(3);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
